// File: rtl/lock_pkg.sv
// Shared types and constants for the canal-lock sequencer.
// States, timer ignore window, actuator bit positions and phase helpers.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPEN_LO = 3'd1,
        ENTER   = 3'd2,
        FILL    = 3'd3,
        OPEN_HI = 3'd4,
        EXIT    = 3'd5,
        DRAIN   = 3'd6,
        FAULT   = 3'd7
    } lock_state_t;

    // timer_done is ignored for this many cycles after a timed-state entry
    localparam int TIMER_GUARD = 2;
    localparam int GUARD_W     = 2;

    localparam int ACT_LOW_GATE  = 0;
    localparam int ACT_HIGH_GATE = 1;
    localparam int ACT_FILL      = 2;
    localparam int ACT_DRAIN     = 3;
    localparam int ACT_W         = 4;

    function automatic logic is_timed(input lock_state_t s);
        return (s == OPEN_LO) || (s == FILL) || (s == OPEN_HI) || (s == DRAIN);
    endfunction

    function automatic logic [ACT_W-1:0] actuators(input lock_state_t s);
        logic [ACT_W-1:0] a;
        a = '0;
        case (s)
            OPEN_LO, ENTER: a[ACT_LOW_GATE]  = 1'b1;
            FILL:           a[ACT_FILL]      = 1'b1;
            OPEN_HI, EXIT:  a[ACT_HIGH_GATE] = 1'b1;
            DRAIN:          a[ACT_DRAIN]     = 1'b1;
            default:        a = '0;
        endcase
        return a;
    endfunction

    function automatic lock_state_t next_phase(input lock_state_t s);
        lock_state_t n;
        case (s)
            IDLE:    n = OPEN_LO;
            OPEN_LO: n = ENTER;
            ENTER:   n = FILL;
            FILL:    n = OPEN_HI;
            OPEN_HI: n = EXIT;
            EXIT:    n = DRAIN;
            DRAIN:   n = IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lock_wdog.sv
// Per-phase watchdog: counts cycles spent in a timed phase and flags expiry.
// Only instantiated when LOCK_SEQ_WATCHDOG_EN is defined; TO_CYC=0 disables expiry.
module lock_wdog #(
    parameter int TO_CYC = 1000,
    parameter int TO_W   = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    logic [TO_W-1:0] count;

    // saturates instead of wrapping so a stuck phase cannot re-arm itself
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + TO_W'(1);
        end
    end

    // count holds cycles already spent; expiry on the TO_CYC-th cycle lands the edge on TO_CYC
    assign expire = (TO_CYC != 0) && run && (count >= TO_W'(TO_CYC - 1));

endmodule

// File: rtl/lock_sequencer.sv
// Canal-lock sequencer: walks gates and valves through one lock cycle using an external timer.
// Optional per-phase watchdog with sticky FAULT state enabled by LOCK_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | lock at rest, waiting for arrive or a pending request
// OPEN_LO | (timed) low gate opening
// ENTER   | low gate open, waiting for boat_in
// FILL    | (timed) fill valve open, chamber rising
// OPEN_HI | (timed) high gate opening
// EXIT    | high gate open, waiting for boat_out
// DRAIN   | (timed) drain valve open, chamber falling
// FAULT   | watchdog expired, actuators off until reset
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int TO_CYC = 1000,
    parameter int TO_W   = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic arrive,
    input  logic boat_in,
    input  logic boat_out,
    input  logic timer_done,
    output logic timer_set,
    output logic low_gate,
    output logic high_gate,
    output logic fill,
    output logic drain,
    output logic busy,
    output logic fault
);

    if (TO_W < 1 || TO_CYC < 0) begin : g_param_check
        $error("lock_sequencer: TO_W must be >= 1 and TO_CYC must be >= 0");
    end

    lock_state_t        state, state_nxt;
    logic               pending, pending_nxt;
    logic [GUARD_W-1:0] guard, guard_nxt;
    logic               done_ok;
    logic               entering;
    logic               timer_set_nxt;
    logic               busy_nxt;
    logic [ACT_W-1:0]   act_q, act_nxt;

`ifdef LOCK_SEQ_WATCHDOG_EN
    logic wd_run;
    logic wd_expire;
    logic fault_q;

    assign wd_run = is_timed(state);

    lock_wdog #(
        .TO_CYC (TO_CYC),
        .TO_W   (TO_W)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_set_nxt),
        .run    (wd_run),
        .expire (wd_expire)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            guard     <= '0;
            timer_set <= 1'b0;
            busy      <= 1'b0;
            act_q     <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            guard     <= guard_nxt;
            timer_set <= timer_set_nxt;
            busy      <= busy_nxt;
            act_q     <= act_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        done_ok     = is_timed(state) && (guard >= GUARD_W'(TIMER_GUARD)) && timer_done;

        if ((state != IDLE) && arrive) begin
            pending_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (arrive || pending) begin
                    state_nxt   = OPEN_LO;
                    pending_nxt = 1'b0;
                end
            end
            OPEN_LO, FILL, OPEN_HI, DRAIN: begin
                if (done_ok) begin
                    state_nxt = next_phase(state);
                end
`ifdef LOCK_SEQ_WATCHDOG_EN
                else if (wd_expire) begin
                    state_nxt = FAULT;
                end
`endif
            end
            ENTER: begin
                if (boat_in) begin
                    state_nxt = FILL;
                end
            end
            EXIT: begin
                if (boat_out) begin
                    state_nxt = DRAIN;
                end
            end
            FAULT: begin
`ifdef LOCK_SEQ_WATCHDOG_EN
                state_nxt = FAULT;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase

        // outputs are decoded from the next state so the registers line up with the state
        entering      = (state_nxt != state);
        if (entering) begin
            guard_nxt = '0;
        end else if (guard < GUARD_W'(TIMER_GUARD)) begin
            guard_nxt = guard + GUARD_W'(1);
        end else begin
            guard_nxt = guard;
        end
        timer_set_nxt = entering && is_timed(state_nxt);
        act_nxt       = actuators(state_nxt);
        busy_nxt      = (state_nxt != IDLE);
    end

`ifdef LOCK_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_nxt == FAULT);
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign low_gate  = act_q[ACT_LOW_GATE];
    assign high_gate = act_q[ACT_HIGH_GATE];
    assign fill      = act_q[ACT_FILL];
    assign drain     = act_q[ACT_DRAIN];

endmodule
